// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES SBox (forward/inverse) with valid/ready handshake,
// per-request tag and op-error sideband, and a synchronous flush.
module aes_sbox_pipe #(
  parameter int NUM_LANES   = 4,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             in_op_i,
  input  logic [8*NUM_LANES-1:0] in_data_i,
  input  logic [TAG_W-1:0]       in_tag_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [8*NUM_LANES-1:0] out_data_o,
  output logic [TAG_W-1:0]       out_tag_o,
  output logic                   out_op_err_o,
  output logic                   busy_o
);

  localparam int DW   = 8 * NUM_LANES;
  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

  logic [DW-1:0]          lut_d;
  logic                   op_inv;
  logic                   op_err;
  logic                   in_fire;

  logic [PIPE_STAGES-1:0] stg_v;
  logic [PIPE_STAGES-1:0] stg_err;
  logic [DW-1:0]          stg_d   [PIPE_STAGES];
  logic [TAG_W-1:0]       stg_tag [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stg_rdy;

  logic [PIPE_STAGES-1:0] up_v;
  logic [PIPE_STAGES-1:0] up_err;
  logic [DW-1:0]          up_d    [PIPE_STAGES];
  logic [TAG_W-1:0]       up_tag  [PIPE_STAGES];

  assign op_inv = (in_op_i == 2'b10);
  assign op_err = ~^in_op_i;

  always_comb begin
    lut_d = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      lut_d[8*k +: 8] = op_inv ? inv_sbox(in_data_i[8*k +: 8]) : fwd_sbox(in_data_i[8*k +: 8]);
    end
  end

  // Stage s can load if any stage from s onward has a hole, or the output drains.
  always_comb begin
    stg_rdy = '0;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      stg_rdy[s] = out_ready_i;
      for (int k = s; k < PIPE_STAGES; k++) begin
        if (!stg_v[k]) stg_rdy[s] = 1'b1;
      end
    end
  end

  assign in_ready_o = ~rst_i & stg_rdy[0];
  assign in_fire    = in_valid_i & in_ready_o;

  always_comb begin
    up_v      = '0;
    up_err    = '0;
    up_d      = '{default: '0};
    up_tag    = '{default: '0};
    up_v[0]   = in_fire;
    up_err[0] = op_err;
    up_d[0]   = lut_d;
    up_tag[0] = in_tag_i;
    for (int s = 1; s < PIPE_STAGES; s++) begin
      up_v[s]   = stg_v[s-1];
      up_err[s] = stg_err[s-1];
      up_d[s]   = stg_d[s-1];
      up_tag[s] = stg_tag[s-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stg_v   <= '0;
      stg_err <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        stg_d[s]   <= '0;
        stg_tag[s] <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (stg_rdy[s]) begin
          stg_v[s] <= up_v[s] & ~flush_i;
          if (up_v[s]) begin
            stg_d[s]   <= up_d[s];
            stg_tag[s] <= up_tag[s];
            stg_err[s] <= up_err[s];
          end
        end else if (flush_i) begin
          stg_v[s] <= 1'b0;
        end
      end
    end
  end

  assign out_valid_o  = stg_v[LAST];
  assign out_data_o   = stg_d[LAST];
  assign out_tag_o    = stg_tag[LAST];
  assign out_op_err_o = stg_err[LAST];
  assign busy_o       = |stg_v;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: a 1-stage and a 2-stage instance share stimulus;
// expected bytes come from hand-copied AES SBox table entries.
module tb_aes_sbox_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  op = 2'b01;
  logic [31:0] data = '0;
  logic [3:0]  tag = '0;

  logic        p1_in_ready, p1_out_valid, p1_out_err, p1_busy;
  logic [31:0] p1_out_data;
  logic [3:0]  p1_out_tag;
  logic        p2_in_ready, p2_out_valid, p2_out_err, p2_busy;
  logic [31:0] p2_out_data;
  logic [3:0]  p2_out_tag;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  sb0 [8] = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5};
  logic [7:0]  sb1 [8] = '{8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0};
  logic [35:0] q [$];
  logic [35:0] exp_e;

  always #5 clk = ~clk;

  aes_sbox_pipe #(.NUM_LANES(4), .PIPE_STAGES(1), .TAG_W(4)) u_p1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(p1_in_ready), .in_op_i(op),
    .in_data_i(data), .in_tag_i(tag),
    .out_valid_o(p1_out_valid), .out_ready_i(out_ready), .out_data_o(p1_out_data),
    .out_tag_o(p1_out_tag), .out_op_err_o(p1_out_err), .busy_o(p1_busy)
  );

  aes_sbox_pipe #(.NUM_LANES(4), .PIPE_STAGES(2), .TAG_W(4)) u_p2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(p2_in_ready), .in_op_i(op),
    .in_data_i(data), .in_tag_i(tag),
    .out_valid_o(p2_out_valid), .out_ready_i(out_ready), .out_data_o(p2_out_data),
    .out_tag_o(p2_out_tag), .out_op_err_o(p2_out_err), .busy_o(p2_busy)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int j, got, acc_stall;
    logic [7:0] b;

    // reset state
    #12;
    chk("rst_p1_valid", 64'(p1_out_valid), 64'd0);
    chk("rst_p2_valid", 64'(p2_out_valid), 64'd0);
    chk("rst_p2_data",  64'(p2_out_data),  64'd0);
    chk("rst_p2_busy",  64'(p2_busy),      64'd0);
    chk("rst_p2_rdy",   64'(p2_in_ready),  64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_p1_rdy", 64'(p1_in_ready), 64'd1);
    chk("rel_p2_rdy", 64'(p2_in_ready), 64'd1);

    // forward then inverse
    in_valid = 1'b1; op = 2'b01; data = 32'h00_01_53_FF; tag = 4'd3;
    tick();
    chk("t1_p1_valid", 64'(p1_out_valid), 64'd1);
    chk("t1_p1_data",  64'(p1_out_data),  64'h637CED16);
    chk("t1_p1_tag",   64'(p1_out_tag),   64'd3);
    chk("t1_p1_err",   64'(p1_out_err),   64'd0);
    chk("t1_p2_empty", 64'(p2_out_valid), 64'd0);
    op = 2'b10; data = 32'h63_7C_ED_16; tag = 4'd5;
    tick();
    chk("t2_p1_data", 64'(p1_out_data), 64'h000153FF);
    chk("t2_p1_tag",  64'(p1_out_tag),  64'd5);
    chk("t2_p2_data", 64'(p2_out_data), 64'h637CED16);
    chk("t2_p2_tag",  64'(p2_out_tag),  64'd3);
    in_valid = 1'b0;
    tick();
    chk("t2_p2_inv",  64'(p2_out_data), 64'h000153FF);
    chk("t2_p2_vld",  64'(p2_out_valid), 64'd1);
    drain();
    chk("t2_idle", 64'(p2_busy), 64'd0);

    // back-to-back stream on the 2-stage pipe
    op = 2'b01;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      b = 8'(i);
      data = {4{b}};
      tag = 4'(i);
      tick();
      chk($sformatf("t3_vld%0d", i), 64'(p2_out_valid), 64'((i >= 1) && (i <= 8)));
      if ((i >= 1) && (i <= 8)) begin
        chk($sformatf("t3_tag%0d", i), 64'(p2_out_tag), 64'(i - 1));
        chk($sformatf("t3_dat%0d", i), 64'(p2_out_data), 64'({4{sb0[i-1]}}));
      end
    end
    drain();

    // back-pressure for 5 cycles while streaming
    j = 0; got = 0; acc_stall = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c >= 5);
      in_valid = (j < 8);
      b = 8'h10 + 8'(j);
      data = {4{b}};
      tag = 4'(j);
      #1;
      if (p2_out_valid && out_ready) begin
        if (q.size() == 0) chk("t4_extra", 64'd1, 64'd0);
        else begin
          exp_e = q.pop_front();
          chk("t4_tag",  64'(p2_out_tag),  64'(exp_e[35:32]));
          chk("t4_data", 64'(p2_out_data), 64'(exp_e[31:0]));
          got++;
        end
      end
      if (in_valid && p2_in_ready) begin
        q.push_back({4'(j), {4{sb1[j]}}});
        j++;
        if (c < 5) acc_stall++;
      end
      if (c >= 2 && c <= 4) begin
        chk("t4_hold_v", 64'(p2_out_valid), 64'd1);
        chk("t4_hold_d", 64'(p2_out_data),  64'hCACACACA);
        chk("t4_hold_t", 64'(p2_out_tag),   64'd0);
      end
      if (c == 4) begin
        chk("t4_acc", 64'(acc_stall), 64'd2);
        chk("t4_rdy", 64'(p2_in_ready), 64'd0);
      end
      tick();
    end
    chk("t4_got",  64'(got), 64'd8);
    chk("t4_left", 64'(q.size()), 64'd0);
    drain();

    // illegal op falls back to forward with error flag
    in_valid = 1'b1; op = 2'b11; data = 32'h0; tag = 4'd1;
    tick();
    chk("t5_p1_err", 64'(p1_out_err), 64'd1);
    op = 2'b01; data = 32'h01010101; tag = 4'd2;
    tick();
    in_valid = 1'b0;
    chk("t5_data", 64'(p2_out_data), 64'h63636363);
    chk("t5_err",  64'(p2_out_err),  64'd1);
    tick();
    chk("t5_data2", 64'(p2_out_data), 64'h7C7C7C7C);
    chk("t5_err2",  64'(p2_out_err),  64'd0);
    drain();

    // flush with two in flight plus a same-cycle handshake
    in_valid = 1'b1; op = 2'b01; data = 32'h02020202; tag = 4'd1;
    tick();
    tag = 4'd2;
    tick();
    chk("t6_busy", 64'(p2_busy), 64'd1);
    tag = 4'd3; flush = 1'b1;
    #1;
    chk("t6_rdy", 64'(p2_in_ready), 64'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_vld",   64'(p2_out_valid), 64'd0);
    chk("t6_busy0", 64'(p2_busy),      64'd0);
    chk("t6_p1bsy", 64'(p1_busy),      64'd0);

    // asynchronous reset mid-stream
    in_valid = 1'b1; data = 32'h03030303; tag = 4'd7;
    tick();
    tick();
    chk("t7_busy", 64'(p2_busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_vld",  64'(p2_out_valid), 64'd0);
    chk("t7_data", 64'(p2_out_data),  64'd0);
    chk("t7_tag",  64'(p2_out_tag),   64'd0);
    chk("t7_err",  64'(p2_out_err),   64'd0);
    chk("t7_busy0", 64'(p2_busy),     64'd0);
    chk("t7_rdy",  64'(p2_in_ready),  64'd0);
    chk("t7_p1v",  64'(p1_out_valid), 64'd0);
    tick();
    chk("t7_ign", 64'(p2_busy), 64'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("t7_idle", 64'(p2_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
